// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-SRAM arbiter:
//   - arb_state_e : arbiter FSM states (ARB = normal round-robin,
//                   LOCK = master 1 owns the SRAM for a bounded burst)
//   - M0 / M1     : master index values used for the pointer and owner tags
//   - CEN_ON, WEN_WR, WEN_RD : SRAM control polarities (active low)
//   - CNT_W       : width of the burst counter (MAX_BURST can be up to 255)
package dmem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic CEN_ON = 1'b0;
    localparam logic WEN_WR = 1'b0;
    localparam logic WEN_RD = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr
// Two-way round-robin picker. Purely combinational.
// Ports:
//   req[1:0] in   request vector, bit i = master i
//   ptr      in   master that wins when both request (M0 or M1)
//   gnt[1:0] out  one-hot grant (all zero when nobody requests)
// A lone requester always wins regardless of the pointer.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || (ptr == M0))) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-master arbiter and sequencer for a single-port synchronous SRAM with
// active-low controls. Master 0 is the CPU data port, master 1 the
// loader/debug port. Each cycle one requester is granted (combinationally);
// the accepted command appears on the SRAM pins the next cycle and read data
// is routed back to its owner the cycle after that.
//
// Handshake: a request is accepted in a cycle where mX_req and mX_gnt are
// both high. A master keeps req/we/addr/wdata stable until it sees gnt.
// rvalid is a single-cycle pulse with no back-pressure; rdata is meaningful
// only while the owner's rvalid is high.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_req/we/addr/wdata     master 0 request; m0_gnt accept strobe
//   m0_rvalid/m0_rdata       master 0 read return
//   m1_*                     same for master 1, plus m1_lock (burst lock)
//   CEN, WEN, OEN, A, D      SRAM command pins (registered; OEN tied low)
//   Q                        SRAM read data, valid the cycle after a read
//   dbg_state                FSM state (0 = ARB, 1 = LOCK)
//   dbg_ptr                  round-robin pointer (0 = master 0)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q,

    output logic              dbg_state,
    output logic              dbg_ptr
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

    // ------------------------------------------------------------------
    // Arbitration FSM state
    // ------------------------------------------------------------------
    arb_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic       lock_hold;
    logic       rr_ptr;
    logic [1:0] rr_gnt;

    // Command register stage
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              own_q, own_d;

    // Return-tag stage
    logic rvalid_q, rvalid_d;
    logic rown_q, rown_d;

    logic accept;
    logic sel;

    // In LOCK, master 1 keeps the SRAM only while it both requests and holds
    // the lock. Any other LOCK cycle is an exit cycle and is arbitrated like
    // ARB with master 0 favoured, since master 0 was starved by the burst.
    assign lock_hold = (state_q == LOCK) && m1_req && m1_lock;
    assign rr_ptr    = (state_q == LOCK) ? M0 : ptr_q;

    dmem_arb_rr u_rr (
        .req ({m1_req, m0_req}),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    assign m0_gnt = lock_hold ? 1'b0 : rr_gnt[0];
    assign m1_gnt = lock_hold ? 1'b1 : rr_gnt[1];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CNT_W'(1);

        if (lock_hold) begin
            // Burst continues; the grant that reaches MAX_BURST ends it and
            // hands priority to master 0.
            if (cnt_inc >= MAX_C) begin
                state_d = ARB;
                ptr_d   = M0;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_inc;
            end
        end else begin
            state_d = ARB;
            ptr_d   = rr_ptr;
            cnt_d   = '0;
            if (m0_req && m1_req) begin
                ptr_d = rr_gnt[0] ? M1 : M0;
            end
            if (rr_gnt[1] && m1_lock) begin
                if (MAX_C <= CNT_W'(1)) begin
                    // A one-grant burst ends as soon as it starts.
                    ptr_d = M0;
                end else begin
                    state_d = LOCK;
                    cnt_d   = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= M0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Command register stage
    // ------------------------------------------------------------------
    assign accept = (m0_gnt && m0_req) || (m1_gnt && m1_req);
    assign sel    = m1_gnt ? M1 : M0;

    always_comb begin
        cen_d = ~CEN_ON;
        wen_d = WEN_RD;
        a_d   = a_q;
        d_d   = d_q;
        own_d = own_q;
        if (accept) begin
            cen_d = CEN_ON;
            if (sel == M1) begin
                wen_d = m1_we ? WEN_WR : WEN_RD;
                a_d   = m1_addr;
                d_d   = m1_wdata;
            end else begin
                wen_d = m0_we ? WEN_WR : WEN_RD;
                a_d   = m0_addr;
                d_d   = m0_wdata;
            end
            own_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cen_q <= ~CEN_ON;
            wen_q <= WEN_RD;
            a_q   <= '0;
            d_q   <= '0;
            own_q <= M0;
        end else begin
            cen_q <= cen_d;
            wen_q <= wen_d;
            a_q   <= a_d;
            d_q   <= d_d;
            own_q <= own_d;
        end
    end

    // ------------------------------------------------------------------
    // Return-tag stage: a read on the pins this cycle returns next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rvalid_d = (cen_q == CEN_ON) && (wen_q == WEN_RD);
        rown_d   = own_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rown_q   <= M0;
        end else begin
            rvalid_q <= rvalid_d;
            rown_q   <= rown_d;
        end
    end

    assign m0_rvalid = rvalid_q && (rown_q == M0);
    assign m1_rvalid = rvalid_q && (rown_q == M1);
    assign m0_rdata  = Q;
    assign m1_rdata  = Q;

    assign CEN = cen_q;
    assign WEN = wen_q;
    assign OEN = 1'b0;
    assign A   = a_q;
    assign D   = d_q;

    assign dbg_state = logic'(state_q);
    assign dbg_ptr   = ptr_q;

endmodule
